// File: rtl/mem_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding and stream byte width.
package mem_loader_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_loader.sv
// Program loader in front of the single-port program/data memory.
// Assembles a byte stream (MSB byte first) into words and writes them to
// consecutive addresses starting at BASE_ADDR. While idle the CPU memory
// port is forwarded unchanged; while loading the loader owns the port.
//
// Handshake: a byte is transferred on every rising edge where in_valid and
// in_ready are both high. in_ready depends only on registered state, never
// on in_valid, and the source must hold in_data stable while in_valid is
// high and in_ready is low.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int BASE_ADDR  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic [1:0]            dbg_state
);

  localparam int BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [BCW-1:0]        BCNT_ONE  = BCW'(1);
  localparam logic [ADDR_WIDTH:0]   WIDX_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   word_idx;
  logic [BCW-1:0]        byte_cnt;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] sum_q;

  logic accept;
  logic last_byte;
  logic last_word;
  logic load_go;

  assign accept    = (state == ST_RECV) && in_valid && !abort;
  assign last_byte = (byte_cnt == LAST_BYTE);
  assign last_word = ((word_idx + WIDX_ONE) == len_q);
  assign load_go   = (state == ST_IDLE) && start && !abort;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort returns to IDLE from any active state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (load_go) state_nxt = (len == '0) ? ST_DONE : ST_RECV;
      end
      ST_RECV: begin
        if (abort)                      state_nxt = ST_IDLE;
        else if (in_valid && last_byte) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        if (abort)          state_nxt = ST_IDLE;
        else if (last_word) state_nxt = ST_DONE;
        else                state_nxt = ST_RECV;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Load datapath: length latch, byte assembly, word index and running checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      word_q   <= '0;
      sum_q    <= '0;
    end else if (load_go) begin
      len_q    <= len;
      word_idx <= '0;
      byte_cnt <= '0;
      sum_q    <= '0;
    end else if (abort) begin
      // Any partially assembled word is dropped; completed words stay summed.
      byte_cnt <= '0;
    end else if (accept) begin
      word_q   <= (word_q << BYTE_WIDTH) | DATA_WIDTH'(in_data);
      byte_cnt <= last_byte ? '0 : byte_cnt + BCNT_ONE;
    end else if (state == ST_WRITE) begin
      sum_q    <= sum_q + word_q;
      word_idx <= word_idx + WIDX_ONE;
    end
  end

  // Output mux: CPU passthrough in IDLE/DONE, loader owns the port otherwise.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    mem_we   = cpu_we;
    mem_addr = cpu_addr;
    mem_data = cpu_data;
    case (state)
      ST_RECV: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        mem_we   = 1'b0;
        mem_addr = BASE + word_idx[ADDR_WIDTH-1:0];
        mem_data = word_q;
      end
      ST_WRITE: begin
        busy     = 1'b1;
        mem_we   = !abort;
        mem_addr = BASE + word_idx[ADDR_WIDTH-1:0];
        mem_data = word_q;
      end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  assign checksum  = sum_q;
  assign dbg_state = state;

endmodule
